score_step_counter: RTL and testbench

Parametrised, prescaled step counter for the Score RAM management path. It generalises the fixed divide-by-3, count-to-2 step counter. Divide ratio and terminal count are programmable at run time, latched on start. Supports one-shot and auto-reload modes, with start/clear/hold control and registered tick, terminal and done outputs. The NW control FSM uses it to pace score-RAM row/column accesses.

---
 rtl/score_cnt_pkg.sv | 17 +
 rtl/score_step_counter_if.sv | 44 ++++
 rtl/score_cnt_prescaler.sv | 39 +++
 rtl/score_step_counter.sv | 144 ++++++++++++++
 tb/tb_score_step_counter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/score_cnt_pkg.sv
// Shared types and constants for the score-RAM step counter.
// Optional down-count support is enabled by defining SCORE_STEP_COUNTER_DOWN_EN.
package score_cnt_pkg;

    localparam int DEF_CNT_W = 4;
    localparam int DEF_PRE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } score_cnt_state_e;

    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/score_step_counter_if.sv
// Control/status bundle between the NW control FSM and the step counter.
// The down input exists only when SCORE_STEP_COUNTER_DOWN_EN is defined.
interface score_step_counter_if
    import score_cnt_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PRE_W = DEF_PRE_W
);

    // Control inputs are level-sampled every clock; start and clear are
    // single-cycle pulses, outputs are registered and valid every cycle.
    logic             start;
    logic             clear;
    logic             en;
    logic [PRE_W-1:0] div;
    logic [CNT_W-1:0] limit;
    logic             reload;
`ifdef SCORE_STEP_COUNTER_DOWN_EN
    logic             down;
`endif
    logic [CNT_W-1:0] count;
    logic             tick;
    logic             term;
    logic             done;
    logic             busy;
    logic [1:0]       state_dbg;

    modport master (
        output start, clear, en, div, limit, reload,
`ifdef SCORE_STEP_COUNTER_DOWN_EN
        output down,
`endif
        input  count, tick, term, done, busy, state_dbg
    );

    modport slave (
        input  start, clear, en, div, limit, reload,
`ifdef SCORE_STEP_COUNTER_DOWN_EN
        input  down,
`endif
        output count, tick, term, done, busy, state_dbg
    );

endinterface

// File: rtl/score_cnt_prescaler.sv
// Prescaler for the step counter: emits a step on every (div+1)-th enabled cycle.
// clr returns the divider to zero and suppresses the step in that cycle.
module score_cnt_prescaler #(
    parameter int PRE_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] div,
    output logic             step
);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;
    logic             hit;

    // Compare before increment so div = all-ones never wraps the counter.
    assign hit  = (pre_q == div);
    assign step = en && !clr && hit;

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = hit ? '0 : pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/score_step_counter.sv
// Programmable prescaled step counter pacing score-RAM row/column accesses.
// Define SCORE_STEP_COUNTER_DOWN_EN to add a latched down-count mode.
module score_step_counter
    import score_cnt_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic                 clk,
    input  logic                 rst,
    score_step_counter_if.slave  bus
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PRE_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             tick_q, tick_d;
    logic             term_q, term_d;
    logic             done_q, done_d;
    logic             busy_q;
    logic             start_acc;
    logic             pre_clr;
    logic             pre_en;
    logic             step;
    logic             at_term;
    logic             down_q;

`ifdef SCORE_STEP_COUNTER_DOWN_EN
    logic down_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            down_q <= 1'b0;
        end else begin
            down_q <= down_d;
        end
    end

    always_comb begin
        down_d = down_q;
        if (start_acc) begin
            down_d = bus.down;
        end
    end
`else
    assign down_q = 1'b0;
`endif

    // Start is ignored while running; clear always wins.
    assign start_acc = bus.start && !bus.clear && (state_q != S_RUN);
    assign pre_clr   = bus.clear || start_acc;
    assign pre_en    = (state_q == S_RUN) && bus.en;
    assign at_term   = down_q ? (count_q == '0) : (count_q == limit_q);

    score_cnt_prescaler #(
        .PRE_W (PRE_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (pre_clr),
        .en   (pre_en),
        .div  (div_q),
        .step (step)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        div_d   = div_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        tick_d  = 1'b0;
        term_d  = 1'b0;
        done_d  = done_q;

        if (bus.clear) begin
            state_d = S_IDLE;
            count_d = '0;
            done_d  = 1'b0;
        end else if (start_acc) begin
            state_d = S_RUN;
            div_d   = bus.div;
            limit_d = bus.limit;
            mode_d  = bus.reload;
            done_d  = 1'b0;
`ifdef SCORE_STEP_COUNTER_DOWN_EN
            count_d = bus.down ? bus.limit : '0;
`else
            count_d = '0;
`endif
        end else if (step) begin
            tick_d = 1'b1;
            if (at_term) begin
                term_d = 1'b1;
                if (mode_q == MODE_RELOAD) begin
                    count_d = down_q ? limit_q : '0;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end else begin
                count_d = down_q ? count_q - CNT_W'(1) : count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            div_q   <= '0;
            limit_q <= '0;
            mode_q  <= MODE_ONESHOT;
            tick_q  <= 1'b0;
            term_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            div_q   <= div_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            tick_q  <= tick_d;
            term_q  <= term_d;
            done_q  <= done_d;
            busy_q  <= (state_d == S_RUN);
        end
    end

    assign bus.count     = count_q;
    assign bus.tick      = tick_q;
    assign bus.term      = term_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_score_step_counter.sv
// Directed plus randomized bench for score_step_counter against a behavioural model.
// Honours SCORE_STEP_COUNTER_DOWN_EN when the design is built with it.
module tb_score_step_counter;
  import score_cnt_pkg::*;

  localparam int CNT_W = 4;
  localparam int PRE_W = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  score_step_counter_if #(.CNT_W(CNT_W), .PRE_W(PRE_W)) bus ();

  score_step_counter #(.CNT_W(CNT_W), .PRE_W(PRE_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: a step happens once (div+1) enabled run cycles have elapsed.
  bit m_run, m_done, m_tick, m_term, m_rel, m_down;
  int m_elapsed, m_cnt, m_div, m_lim;
  int cyc;
  int tick_cyc[$];
  int term_cyc[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_tick = 0; m_term = 0; m_rel = 0; m_down = 0;
    m_elapsed = 0; m_cnt = 0; m_div = 0; m_lim = 0;
  endtask

  task automatic model_cycle(input bit s, input bit c, input bit e, input int d,
                             input int l, input bit r, input bit dn);
    m_tick = 0;
    m_term = 0;
    if (c) begin
      m_run = 0; m_done = 0; m_cnt = 0; m_elapsed = 0;
    end else if (s && !m_run) begin
      m_div = d; m_lim = l; m_rel = r; m_down = dn;
      m_cnt = dn ? l : 0;
      m_elapsed = 0; m_done = 0; m_run = 1;
    end else if (m_run && e) begin
      m_elapsed++;
      if (m_elapsed == m_div + 1) begin
        m_elapsed = 0;
        m_tick = 1;
        if (m_cnt == (m_down ? 0 : m_lim)) begin
          m_term = 1;
          if (m_rel) m_cnt = m_down ? m_lim : 0;
          else begin m_run = 0; m_done = 1; end
        end else begin
          m_cnt = m_down ? m_cnt - 1 : m_cnt + 1;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("count", 32'(bus.count), 32'(m_cnt));
    check("tick",  32'(bus.tick),  32'(m_tick));
    check("term",  32'(bus.term),  32'(m_term));
    check("done",  32'(bus.done),  32'(m_done));
    check("busy",  32'(bus.busy),  32'(m_run));
  endtask

  // Apply one cycle of inputs, advance the model at the edge, check 1ns later.
  task automatic drive(input bit s, input bit c, input bit e, input int d,
                       input int l, input bit r, input bit dn);
    bus.start  = s;
    bus.clear  = c;
    bus.en     = e;
    bus.div    = PRE_W'(d);
    bus.limit  = CNT_W'(l);
    bus.reload = r;
`ifdef SCORE_STEP_COUNTER_DOWN_EN
    bus.down   = dn;
`endif
    @(posedge clk);
    model_cycle(s, c, e, d, l, r, dn);
    cyc++;
    #1;
    compare_all();
    if (bus.tick === 1'b1) tick_cyc.push_back(cyc);
    if (bus.term === 1'b1) term_cyc.push_back(cyc);
  endtask

  task automatic idle_cycles(input int n, input bit e);
    for (int i = 0; i < n; i++) drive(0, 0, e, 0, 0, 0, 0);
  endtask

  initial begin
    bus.start = 0; bus.clear = 0; bus.en = 0; bus.div = '0; bus.limit = '0; bus.reload = 0;
`ifdef SCORE_STEP_COUNTER_DOWN_EN
    bus.down = 0;
`endif
    model_reset();
    cyc = 0;
    rst = 1'b1;
    #12;
    compare_all();
    rst = 1'b0;
    @(negedge clk);

    // div=2, limit=2, one-shot: ticks at cycles 4, 7, 10; term at 10.
    cyc = 0; tick_cyc.delete(); term_cyc.delete();
    drive(1, 0, 1, 2, 2, 0, 0);
    idle_cycles(13, 1);
    check("t1_tick_num", 32'(tick_cyc.size()), 32'd3);
    if (tick_cyc.size() == 3) begin
      check("t1_tick0", 32'(tick_cyc[0]), 32'd4);
      check("t1_tick1", 32'(tick_cyc[1]), 32'd7);
      check("t1_tick2", 32'(tick_cyc[2]), 32'd10);
    end
    check("t1_term_num", 32'(term_cyc.size()), 32'd1);
    if (term_cyc.size() == 1) check("t1_term_cyc", 32'(term_cyc[0]), 32'd10);

    // div=0, limit=3, auto-reload.
    drive(1, 0, 1, 0, 3, 1, 0);
    idle_cycles(12, 1);
    drive(0, 1, 1, 0, 0, 0, 0);

    // div=1, limit=5, en toggling: one step every 4 cycles.
    tick_cyc.delete(); term_cyc.delete();
    drive(1, 0, 1, 1, 5, 0, 0);
    for (int i = 0; i < 30; i++) drive(0, 0, (i % 2) == 0, 0, 0, 0, 0);
    check("t3_ticks", 32'(tick_cyc.size()), 32'd6);
    check("t3_terms", 32'(term_cyc.size()), 32'd1);

    // limit=0, div=3, one-shot: single terminal tick 5 cycles after start.
    cyc = 0; tick_cyc.delete(); term_cyc.delete();
    drive(1, 0, 1, 3, 0, 0, 0);
    idle_cycles(8, 1);
    check("t4_ticks", 32'(tick_cyc.size()), 32'd1);
    if (term_cyc.size() == 1) check("t4_term_cyc", 32'(term_cyc[0]), 32'd5);
    else check("t4_term_num", 32'(term_cyc.size()), 32'd1);

    // Mid-run start ignored, then clear on the terminal step.
    drive(1, 0, 1, 0, 1, 0, 0);
    drive(1, 0, 1, 3, 9, 1, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    idle_cycles(3, 1);

    // Async reset mid-run with count=3.
    drive(1, 0, 1, 0, 9, 1, 0);
    idle_cycles(3, 1);
    check("t6_pre_count", 32'(bus.count), 32'd3);
    #2 rst = 1'b1;
    model_reset();
    #1 compare_all();
    #1 rst = 1'b0;
    idle_cycles(2, 1);

`ifdef SCORE_STEP_COUNTER_DOWN_EN
    // Down-count one-shot from 3.
    drive(1, 0, 1, 0, 3, 0, 1);
    idle_cycles(6, 1);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit s, c, e, r, dn;
      s = ($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 40) == 0);
      e = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 1);
`ifdef SCORE_STEP_COUNTER_DOWN_EN
      dn = $urandom_range(0, 1);
`else
      dn = 0;
`endif
      drive(s, c, e, $urandom_range(0, 3), $urandom_range(0, 15), r, dn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
